// File: rtl/prog_seq_counter.sv
// Programmable-sequence counter: next count comes from a writable successor table.
// Optional self-loop detection on `stuck` when SEQ_STUCK_DETECT_EN is defined.
module prog_seq_counter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned START = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             stuck
);

    localparam int unsigned      DEPTH   = 2 ** WIDTH;
    localparam logic [WIDTH-1:0] START_V = WIDTH'(START);

    logic [WIDTH-1:0] seq_table [DEPTH];
    logic [WIDTH-1:0] next_val;

    // Pre-edge table contents, so a same-cycle write never affects the step.
    assign next_val = seq_table[count];

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= START_V;
            wrap  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                seq_table[i] <= WIDTH'(i + 1);
            end
        end else begin
            if (wr_en) begin
                seq_table[wr_addr] <= wr_data;
            end
            if (load) begin
                count <= load_val;
                wrap  <= 1'b0;
            end else if (en) begin
                count <= next_val;
                wrap  <= (next_val == START_V);
            end else begin
                wrap  <= 1'b0;
            end
        end
    end

`ifdef SEQ_STUCK_DETECT_EN
    always_ff @(posedge clk) begin
        if (clear || load) begin
            stuck <= 1'b0;
        end else if (en && (next_val == count)) begin
            stuck <= 1'b1;
        end
    end
`else
    assign stuck = 1'b0;
`endif

endmodule
